noc_flit_decoder: RTL and testbench
===================================

Name: noc_flit_decoder

Overview:
Clocked router-to-core receive path for the 11-bit NoC flit format: | 7-bit Hamming(7,4) codeword [10:4] | 4-bit address [3:0] |.
- Accepts flits and their 2-bit control tag over valid/ready.
- Computes the syndrome and corrects any single-bit codeword error.
- Repacks each flit into the 8-bit bucket format | 4-bit data [7:4] | 4-bit address [3:0] |.
- Buffers results in a small output FIFO for the core/data-bucket side.
- Maintains saturating statistics counters.

Parameters:
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
CNT_W, 16, width of corrected/dropped counters

Ports:
clk  in  1  clock (rising edge)
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  flit present
in_ready  out  1  flit can be accepted this cycle
in_flit  in  11  flit {codeword c[6:0], addr[3:0]}
in_ctrl  in  2  control tag; 2'd2 = data flit
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
out_byte  out  8  {data[3:0], addr[3:0]}
out_corrected  out  1  head entry had a bit corrected
clr_counts  in  1  synchronous clear of both counters
corr_count  out  CNT_W  flits with nonzero syndrome (saturating)
drop_count  out  CNT_W  flits dropped for in_ctrl != 2 (saturating)
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, async): in_ready=0, out_valid=0, out_byte=0, out_corrected=0, counters=0, fifo_level=0, S1 empty, FIFO pointers 0. in_ready rises the first cycle after deassertion.
- Codeword layout: c0=P1, c1=P2, c2=D1, c3=P4, c4=D2, c5=D3, c6=D4.
- Syndrome bits: s1=c0^c2^c4^c6; s2=c1^c2^c5^c6; s4=c3^c4^c5^c6; s={s4,s2,s1}.
- Correction: if s!=0, invert c[s-1]. Data nibble = {c6,c5,c4,c2} after correction. Address passes through unmodified.
- Error coverage: single-bit errors only. Double errors are silently miscorrected, with no detection flag.
- Stage S1: on in_valid&&in_ready, capture {in_flit,in_ctrl} into the S1 register (s1_valid=1).
- Stage S2 (next edge):
  - ctrl==2: write the decoded byte plus corrected flag (s!=0) into the FIFO tail.
  - ctrl!=2: discard and increment drop_count.
- Latency: a flit accepted at edge N is visible at out_valid after edge N+1 when the FIFO was empty. Sustained throughput is 1 flit/cycle.
- Flow control:
  - in_ready = (fifo_level + s1_valid) < FIFO_DEPTH.
  - This credit rule guarantees S2 never writes a full FIFO. No stall logic is needed in S1.
- FIFO:
  - Show-ahead: out_byte and out_corrected reflect the head whenever out_valid=1.
  - A pop occurs on out_valid&&out_ready.
  - Simultaneous push and pop leaves the level unchanged. Pop from empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Output stability: out_byte is stable while out_valid&&!out_ready.
- Counters:
  - corr_count increments once per written flit with s!=0. Dropped flits are never counted as corrected.
  - Both counters saturate at 2^CNT_W-1.
  - clr_counts has priority over an increment in the same cycle; the counter becomes 0.
- Mid-operation reset: the S1 contents and all FIFO entries are lost. There is no partial output after reset.

Test Plan:
1. Clean flit: in_flit=11'h525, ctrl=2 -> two cycles later out_byte=8'hA5, out_corrected=0, corr_count=0.
2. Single-bit error: in_flit=11'h565 (c2 flipped, s=3) -> out_byte=8'hA5, out_corrected=1, corr_count=1. Repeat for each of the 7 bit positions -> always 8'hA5, corr_count=7 (8 including the first).
3. Control drop: in_flit=11'h525, ctrl=0 -> no output, drop_count=1, fifo_level=0. Then ctrl=2 -> 8'hA5 delivered.
4. Backpressure/full: out_ready=0, stream 6 flits back-to-back:
   - in_ready falls after 4 accepts (level 3 + s1 1) and fifo_level reaches 4.
   - Then raise out_ready -> all 4 delivered in order, remaining flits accepted, no loss or duplication.
5. Concurrent push/pop at level 2 for 10 cycles -> level holds at 2 and data order is preserved across pointer wrap.
6. Counter saturation and clear (CNT_W=2): 5 erroneous flits -> corr_count=3. clr_counts asserted with an erroneous flit in S2 -> corr_count=0. Async reset mid-stream -> out_valid=0 and fifo_level=0 immediately.

Source files
------------

// File: rtl/noc_flit_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : noc_flit_decoder
// Brief    : NoC flit receive path. It performs Hamming(7,4) single-error
//            correction and repacks flits into bytes behind a credit-gated
//            show-ahead FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module noc_flit_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [10:0]                   in_flit,
    input  logic [1:0]                    in_ctrl,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_byte,
    output logic                          out_corrected,
    input  logic                          clr_counts,
    output logic [CNT_W-1:0]              corr_count,
    output logic [CNT_W-1:0]              drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                 c_LVL_W     = c_PTR_W + 1;
    localparam logic [1:0]         c_CTRL_DATA = 2'd2;
    localparam logic [c_LVL_W:0]   c_DEPTH     = (c_LVL_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = '1;

    logic                 r_run;
    logic                 r_s1_valid;
    logic [10:0]          r_s1_flit;
    logic [1:0]           r_s1_ctrl;
    logic [8:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [CNT_W-1:0]     r_corr_count;
    logic [CNT_W-1:0]     r_drop_count;

    logic [6:0]           w_cw;
    logic [6:0]           w_flip;
    logic [6:0]           w_fix;
    logic [2:0]           w_syn;
    logic [3:0]           w_data;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_has_err;
    logic [c_LVL_W:0]     w_credit;

    // Syndrome directly names the 1-based position of a single flipped bit
    assign w_cw      = r_s1_flit[10:4];
    assign w_syn     = {w_cw[3] ^ w_cw[4] ^ w_cw[5] ^ w_cw[6],
                        w_cw[1] ^ w_cw[2] ^ w_cw[5] ^ w_cw[6],
                        w_cw[0] ^ w_cw[2] ^ w_cw[4] ^ w_cw[6]};
    assign w_has_err = (w_syn != 3'd0);
    assign w_flip    = w_has_err ? (7'd1 << (w_syn - 3'd1)) : 7'd0;
    assign w_fix     = w_cw ^ w_flip;
    assign w_data    = {w_fix[6], w_fix[5], w_fix[4], w_fix[2]};

    assign w_push    = r_s1_valid && (r_s1_ctrl == c_CTRL_DATA);
    assign w_drop    = r_s1_valid && (r_s1_ctrl != c_CTRL_DATA);
    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready;

    // Credit counts the flit still in S1, so S2 can never overrun the FIFO
    assign w_credit  = {1'b0, r_level} + {{c_LVL_W{1'b0}}, r_s1_valid};
    assign in_ready  = r_run && (w_credit < c_DEPTH);
    assign w_accept  = in_valid && in_ready;

    assign out_byte      = out_valid ? r_mem[r_rd_ptr][7:0] : 8'd0;
    assign out_corrected = out_valid ? r_mem[r_rd_ptr][8]   : 1'b0;
    assign fifo_level    = r_level;
    assign corr_count    = r_corr_count;
    assign drop_count    = r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_flit  <= 11'd0;
            r_s1_ctrl  <= 2'd0;
        end else begin
            r_run      <= 1'b1;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_flit <= in_flit;
                r_s1_ctrl <= in_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_has_err, w_data, r_s1_flit[3:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_count <= '0;
            r_drop_count <= '0;
        end else if (clr_counts) begin
            r_corr_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push && w_has_err && (r_corr_count != c_CNT_MAX)) begin
                r_corr_count <= r_corr_count + 1'b1;
            end
            if (w_drop && (r_drop_count != c_CNT_MAX)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_flit_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_noc_flit_decoder
// Brief    : Scoreboard bench for noc_flit_decoder (main instance plus a
//            CNT_W=2 instance for saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_flit_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_corrected, clr_counts;
    logic [10:0] in_flit;
    logic [1:0]  in_ctrl;
    logic [7:0]  out_byte;
    logic [15:0] corr_count, drop_count;
    logic [2:0]  fifo_level;

    logic        s_valid, s_ready, s_out_valid, s_out_ready, s_out_corr, s_clr;
    logic [10:0] s_flit;
    logic [1:0]  s_ctrl;
    logic [7:0]  s_out_byte;
    logic [1:0]  s_corr, s_drop;
    logic [2:0]  s_level;

    logic [8:0]  q[$];
    logic [8:0]  mon_exp;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [6:0]  cw_tab  [3] = '{7'h00, 7'h52, 7'h7F};
    logic [3:0]  dat_tab [3] = '{4'h0, 4'hA, 4'hF};

    always #5 clk = ~clk;

    noc_flit_decoder #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_flit(in_flit), .in_ctrl(in_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .out_byte(out_byte), .out_corrected(out_corrected),
        .clr_counts(clr_counts), .corr_count(corr_count), .drop_count(drop_count),
        .fifo_level(fifo_level)
    );

    noc_flit_decoder #(.FIFO_DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
        .in_flit(s_flit), .in_ctrl(s_ctrl), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_byte(s_out_byte), .out_corrected(s_out_corr),
        .clr_counts(s_clr), .corr_count(s_corr), .drop_count(s_drop),
        .fifo_level(s_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake on the output pops one expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %h expected none", out_byte);
            end else begin
                mon_exp = q.pop_front();
                if ({out_corrected, out_byte} !== mon_exp) begin
                    n_err++;
                    $display("FAIL out_entry: got corr=%b byte=%h expected corr=%b byte=%h",
                             out_corrected, out_byte, mon_exp[8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic send(input logic [10:0] f, input logic [1:0] c, input logic [8:0] exp);
        int k = 0;
        in_flit  = f;
        in_ctrl  = c;
        in_valid = 1'b1;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (c == 2'd2) q.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_sat(input logic [10:0] f, input logic [1:0] c);
        int k = 0;
        s_flit  = f;
        s_ctrl  = c;
        s_valid = 1'b1;
        while (!s_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!s_ready) check("send_sat_timeout", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; in_ctrl = '0;
        out_ready = 1'b1; clr_counts = 1'b0;
        s_valid = 1'b0; s_flit = '0; s_ctrl = '0; s_out_ready = 1'b1; s_clr = 1'b0;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'd0);
        check("rst_out_corrected", 32'(out_corrected), 32'd0);
        check("rst_corr_count", 32'(corr_count), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_before_first_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_first_edge", 32'(in_ready), 32'd1);

        // Clean flit and two-edge latency
        send(11'h525, 2'd2, 9'h0A5);
        check("lat_s1_only", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_out_byte", 32'(out_byte), 32'hA5);
        drain();
        check("clean_corr_count", 32'(corr_count), 32'd0);

        // Single-bit error in every codeword position
        send(11'h565, 2'd2, 9'h1A5);
        for (int i = 0; i < 7; i++) begin
            logic [6:0] cw;
            cw = 7'h52 ^ (7'd1 << i);
            send({cw, 4'h5}, 2'd2, 9'h1A5);
        end
        drain();
        check("err_corr_count", 32'(corr_count), 32'd8);

        // Control drop
        send(11'h525, 2'd0, 9'h000);
        repeat (2) begin @(posedge clk); #1; end
        check("drop_count", 32'(drop_count), 32'd1);
        check("drop_level", 32'(fifo_level), 32'd0);
        check("drop_no_output", 32'(out_valid), 32'd0);
        send(11'h525, 2'd2, 9'h0A5);
        drain();
        check("drop_corr_unchanged", 32'(corr_count), 32'd8);

        // Backpressure up to full
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send({cw_tab[i % 3], 4'(i)}, 2'd2, {1'b0, dat_tab[i % 3], 4'(i)});
        check("full_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_still_not_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 4; i < 6; i++)
            send({cw_tab[i % 3], 4'(i)}, 2'd2, {1'b0, dat_tab[i % 3], 4'(i)});
        drain();
        @(posedge clk); #1;
        check("full_drained_level", 32'(fifo_level), 32'd0);

        // Steady push/pop at level 2 across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send({cw_tab[i % 3], 4'(i + 8)}, 2'd2, {1'b0, dat_tab[i % 3], 4'(i + 8)});
        check("steady_prefill_level", 32'(fifo_level), 32'd2);
        out_ready = 1'b1;
        for (int i = 3; i < 13; i++) begin
            send({cw_tab[i % 3], 4'(i + 8)}, 2'd2, {1'b0, dat_tab[i % 3], 4'(i + 8)});
            check("steady_level", 32'(fifo_level), 32'd2);
        end
        drain();

        // Saturation and clear on the narrow-counter instance
        for (int i = 0; i < 5; i++) send_sat(11'h565, 2'd2);
        repeat (3) begin @(posedge clk); #1; end
        check("sat_corr_count", 32'(s_corr), 32'd3);
        for (int i = 0; i < 4; i++) send_sat(11'h525, 2'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("sat_drop_count", 32'(s_drop), 32'd3);
        send_sat(11'h565, 2'd2);
        s_clr = 1'b1;
        @(posedge clk); #1;
        s_clr = 1'b0;
        check("clr_priority_corr", 32'(s_corr), 32'd0);
        check("clr_drop", 32'(s_drop), 32'd0);
        send_sat(11'h565, 2'd2);
        @(posedge clk); #1;
        check("post_clr_count", 32'(s_corr), 32'd1);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send({cw_tab[i % 3], 4'(i)}, 2'd2, {1'b0, dat_tab[i % 3], 4'(i)});
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_level", 32'(fifo_level), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        check("async_rst_out_byte", 32'(out_byte), 32'd0);
        out_ready = 1'b1;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_no_stale", 32'(out_valid), 32'd0);
        send({7'h7F, 4'h3}, 2'd2, 9'h0F3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
